// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and helpers for the BRAM round-robin arbiter
package bram_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  // Tag index is sized for MAX_REQ so the type does not depend on the top-level parameter.
  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr, input int n);
    logic [IDX_W-1:0] nxt;
    if (32'(ptr) + 32'd1 >= 32'(n)) nxt = '0;
    else                             nxt = ptr + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first active request at or after ptr
module rr_pick
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam int PW = $clog2(NUM_REQ);

  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[PW'(c)]) begin
        any            = 1'b1;
        gnt[PW'(c)]    = 1'b1;
        idx            = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/bram_rr_arbiter.sv
// rtl/bram_rr_arbiter.sv - round-robin sharing of one BRAM port pair between NUM_REQ requesters
module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      bram_we,
  output logic [ADDR_W-1:0]         bram_wr_addr,
  output logic [ADDR_W-1:0]         bram_rd_addr,
  output logic [DATA_W-1:0]         bram_wdata,
  input  logic [DATA_W-1:0]         bram_rdata
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  logic               bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  rd_tag_t            tag_q [RD_LAT+1];
  rd_tag_t            tag_d [RD_LAT+1];
  rd_tag_t            tag_out;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Nothing is offered to requesters while the arbiter is held in reset.
  assign gnt = reset_n ? pick_gnt : '0;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        win_we    = req_we[i];
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d     = win_any ? rr_next(win_idx, NUM_REQ) : ptr_q;
    bram_we_d = win_any && win_we;
    wr_addr_d = (win_any && win_we)  ? win_addr  : wr_addr_q;
    wdata_d   = (win_any && win_we)  ? win_wdata : wdata_q;
    rd_addr_d = (win_any && !win_we) ? win_addr  : rd_addr_q;
    tag_d[0]  = '{v: win_any && !win_we, idx: win_idx};
    for (int s = 1; s <= RD_LAT; s++) tag_d[s] = tag_q[s-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      bram_we_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wdata_q   <= '0;
      for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      bram_we_q <= bram_we_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wdata_q   <= wdata_d;
      for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= tag_d[s];
    end
  end

  // Last tag stage lines up with bram_rdata for the read it tracks.
  always_comb begin
    tag_out = tag_q[RD_LAT];
    rvalid  = '0;
    for (int i = 0; i < NUM_REQ; i++) rvalid[i] = tag_out.v && (tag_out.idx == IDX_W'(i));
    rdata   = tag_out.v ? bram_rdata : '0;
  end

  assign bram_we      = bram_we_q;
  assign bram_wr_addr = wr_addr_q;
  assign bram_rd_addr = rd_addr_q;
  assign bram_wdata   = wdata_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_we_chk
    a_we_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (req[g] && !gnt[g]) |=> (!req[g] || $stable(req_we[g])));
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// tb/tb_bram_rr_arbiter.sv - randomized self-checking bench for bram_rr_arbiter
module tb_bram_rr_arbiter;

  localparam int N      = 4;
  localparam int AW     = 8;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req, req_we, gnt, rvalid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rdata, bram_wdata, bram_rdata;
  logic              bram_we;
  logic [AW-1:0]     bram_wr_addr, bram_rd_addr;

  bram_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .bram_we      (bram_we),
    .bram_wr_addr (bram_wr_addr),
    .bram_rd_addr (bram_rd_addr),
    .bram_wdata   (bram_wdata),
    .bram_rdata   (bram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM with RD_LAT cycles from rd_addr to rdata.
  logic [DW-1:0] bram_mem [256];
  logic [DW-1:0] rd_pipe  [RD_LAT];
  always @(posedge clk) begin
    if (bram_we) bram_mem[bram_wr_addr] <= bram_wdata;
    rd_pipe[0] <= bram_mem[bram_rd_addr];
    for (int s = 1; s < RD_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign bram_rdata = rd_pipe[RD_LAT-1];

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  logic [DW-1:0] ref_mem [256];
  bit            pend   [N];
  bit            p_we   [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];
  rd_exp_t       rq [$];
  int            mptr, cyc, errors, checks, last_kind;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  bit            rearm;
  logic [N-1:0]  obs_gnt, obs_rv;
  logic [DW-1:0] obs_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_data[i] = d;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]                = pend[i];
      req_we[i]             = p_we[i];
      req_addr[i*AW +: AW]  = p_addr[i];
      req_wdata[i*DW +: DW] = p_data[i];
    end
  endtask

  task automatic model_reset();
    mptr = 0; last_kind = 0; rq.delete();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  task automatic run_cycle();
    int            w;
    logic [N-1:0]  exp_gnt, exp_rv;
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    drive();
    #1;
    w = -1;
    for (int k = 0; k < N; k++) if (w < 0 && pend[(mptr + k) % N]) w = (mptr + k) % N;
    exp_gnt = '0;
    if (w >= 0) exp_gnt[w] = 1'b1;
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("bram_we", 64'(bram_we), 64'(last_kind == 1));
    if (last_kind == 1) begin
      check("wr_addr", 64'(bram_wr_addr), 64'(last_addr));
      check("wdata", 64'(bram_wdata), 64'(last_data));
    end
    if (last_kind == 2) check("rd_addr", 64'(bram_rd_addr), 64'(last_addr));
    exp_rv = '0;
    exp_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv[rq[0].idx] = 1'b1;
      exp_rd = rq[0].data;
      void'(rq.pop_front());
    end
    check("rvalid", 64'(rvalid), 64'(exp_rv));
    if (exp_rv != '0) check("rdata", 64'(rdata), 64'(exp_rd));
    obs_gnt = gnt; obs_rv = rvalid; obs_rd = rdata;
    last_kind = 0;
    if (w >= 0) begin
      if (p_we[w]) begin
        ref_mem[p_addr[w]] = p_data[w];
        last_kind = 1;
      end else begin
        rq.push_back('{w, ref_mem[p_addr[w]], cyc + RD_LAT + 1});
        last_kind = 2;
      end
      last_addr = p_addr[w];
      last_data = p_data[w];
      pend[w]   = 1'b0;
      mptr      = (w + 1) % N;
      if (rearm) set_req(w, 1'b0, AW'($urandom_range(255, 0)), '0);
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    errors = 0; checks = 0; cyc = 0; rearm = 1'b0;
    last_addr = '0; last_data = '0;
    for (int a = 0; a < 256; a++) begin
      ref_mem[a]  = $urandom;
      bram_mem[a] = ref_mem[a];
    end
    model_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
    reset_n = 1'b0;
    drive();
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_we", 64'(bram_we), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_addrs", 64'({bram_wr_addr, bram_rd_addr}), 64'd0);
    check("rst_wdata", 64'(bram_wdata), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // All four held: strict rotation starting at requester 0
    rearm = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run_cycle();
      check("rot_seq", 64'(obs_gnt), 64'(4'b0001 << (k % 4)));
    end
    rearm = 1'b0;
    repeat (8) run_cycle();

    // Write by r2 then read-back by r1 on consecutive grants
    set_req(2, 1'b1, 8'h10, 32'hDEADBEEF);
    run_cycle();
    check("wr_gnt", 64'(obs_gnt), 64'(4'b0100));
    set_req(1, 1'b0, 8'h10, '0);
    run_cycle();
    check("rd_gnt", 64'(obs_gnt), 64'(4'b0010));
    repeat (RD_LAT) run_cycle();
    run_cycle();
    check("wr_rd_rvalid", 64'(obs_rv), 64'(4'b0010));
    check("wr_rd_rdata", 64'(obs_rd), 64'(32'hDEADBEEF));
    repeat (2) run_cycle();

    // Back-to-back reads by r0 then r3
    set_req(0, 1'b0, 8'h21, '0);
    run_cycle();
    set_req(3, 1'b0, 8'h22, '0);
    run_cycle();
    repeat (RD_LAT - 1) run_cycle();
    run_cycle();
    check("b2b_rv0", 64'(obs_rv), 64'(4'b0001));
    check("b2b_rd0", 64'(obs_rd), 64'(ref_mem[8'h21]));
    run_cycle();
    check("b2b_rv3", 64'(obs_rv), 64'(4'b1000));
    check("b2b_rd3", 64'(obs_rd), 64'(ref_mem[8'h22]));
    repeat (2) run_cycle();

    // Reset pulse while a read is in flight
    set_req(1, 1'b0, 8'h33, '0);
    run_cycle();
    @(negedge clk);
    model_reset();
    drive();
    reset_n = 1'b0;
    #1;
    check("midrst_rvalid", 64'(rvalid), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (4) run_cycle();
    set_req(0, 1'b0, 8'h40, '0);
    set_req(3, 1'b0, 8'h41, '0);
    run_cycle();
    check("ptr_after_rst", 64'(obs_gnt), 64'(4'b0001));

    // Only r3 pending with ptr=1, then wrap back to 0
    run_cycle();
    check("lone_r3", 64'(obs_gnt), 64'(4'b1000));
    set_req(0, 1'b0, 8'h42, '0);
    set_req(1, 1'b0, 8'h43, '0);
    run_cycle();
    check("wrap_to_0", 64'(obs_gnt), 64'(4'b0001));
    repeat (6) run_cycle();

    // Random traffic on a small address window to force write/read collisions
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1)
          set_req(i, 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), $urandom);
      end
      run_cycle();
    end
    repeat (12) run_cycle();
    check("reads_drained", 64'(rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
